// File: rtl/uart_tx_port.sv
// uart_tx_port: FIFO-buffered byte transmitter. Each byte is presented on txdata,
// then strobed on txclk, paced by the host's txready flow control.
module uart_tx_port #(
   parameter int DEPTH      = 8,
   parameter int STROBE_CYC = 2,
   parameter int GAP_CYC    = 1
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   input  logic                   clr_ovf,
   input  logic                   txready,
   output logic [7:0]             txdata,
   output logic                   txclk,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   overflow
);
   localparam int AW          = $clog2(DEPTH);
   localparam int MAX_CYC     = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
   localparam int TW          = $clog2(MAX_CYC + 1);
   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   state_t                 state_reg, state_next;
   logic [TW-1:0]          tmr_reg, tmr_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_in;
   logic                   rdy_s;

   logic [7:0]             mem [DEPTH];
   logic [AW-1:0]          rd_ptr_reg, wr_ptr_reg;
   logic [AW:0]            count_reg;
   logic [7:0]             txdata_reg;
   logic                   txclk_reg;
   logic                   overflow_reg;

   logic                   pop, push, drop;

   // txready is asynchronous to clk; only the last synchronizer stage is used
   assign sync_in = {sync_reg[SYNC_STAGES-2:0], txready};
   assign rdy_s   = sync_reg[SYNC_STAGES-1];

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst)
               sync_reg[gi] <= 1'b0;
            else
               sync_reg[gi] <= sync_in[gi];
         end
      end
   endgenerate

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && full && !pop;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg <= IDLE;
         tmr_reg   <= '0;
         txclk_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         tmr_reg   <= tmr_next;
         txclk_reg <= (state_next == STROBE);
      end
   end

   always_comb begin
      state_next = state_reg;
      tmr_next   = tmr_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rdy_s && !empty) begin
               pop        = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            state_next = STROBE;
            tmr_next   = TW'(STROBE_CYC - 1);
         end
         STROBE: begin
            if (tmr_reg == '0) begin
               state_next = GAP;
               tmr_next   = TW'(GAP_CYC - 1);
            end else begin
               tmr_next = tmr_reg - TW'(1);
            end
         end
         GAP: begin
            if (tmr_reg == '0)
               state_next = IDLE;
            else
               tmr_next = tmr_reg - TW'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= wr_data;
   end

   // txdata is the registered read port of the buffer and holds until the next pop
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         txdata_reg   <= 8'h00;
         overflow_reg <= 1'b0;
      end else begin
         if (pop) begin
            txdata_reg <= mem[rd_ptr_reg];
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (drop)
            overflow_reg <= 1'b1;
         else if (clr_ovf)
            overflow_reg <= 1'b0;
      end
   end

   assign txdata   = txdata_reg;
   assign txclk    = txclk_reg;
   assign count    = count_reg;
   assign busy     = (state_reg != IDLE);
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed and randomized checks of uart_tx_port against a
// transaction-level model (byte queue plus time-since-pop phase arithmetic).
module tb_uart_tx_port;
   localparam int DEPTH = 8;
   localparam int S     = 2;
   localparam int G     = 1;

   logic       clk = 1'b0;
   logic       nrst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       clr_ovf;
   logic       txready;
   logic [7:0] txdata;
   logic       txclk;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       busy;
   logic       overflow;

   uart_tx_port #(.DEPTH(DEPTH), .STROBE_CYC(S), .GAP_CYC(G)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .txready  (txready),
      .txdata   (txdata),
      .txclk    (txclk),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queued bytes, last popped byte, sticky overflow, 2-cycle view
   // of txready, and the edge index of the most recent pop (phase = e - last_pop).
   logic [7:0] mq[$];
   logic [7:0] sb_q[$];
   logic [7:0] m_txdata;
   logic       m_ovf;
   logic       r1, r2;
   int         e = 0;
   int         last_pop = -100;

   localparam logic [16:0] RESET_VEC = {8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};

   function automatic logic [16:0] exp_vec();
      int d;
      logic clk_e, busy_e, full_e, empty_e;
      logic [3:0] cnt_e;
      d       = e - last_pop;
      clk_e   = (d >= 1) && (d <= S);
      busy_e  = (d <= S + G);
      cnt_e   = 4'(mq.size());
      full_e  = (mq.size() == DEPTH);
      empty_e = (mq.size() == 0);
      return {m_txdata, clk_e, busy_e, cnt_e, full_e, empty_e, m_ovf};
   endfunction

   function automatic logic [16:0] obs_vec();
      return {txdata, txclk, busy, count, full, empty, overflow};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_txdata = 8'h00;
      m_ovf    = 1'b0;
      r1       = 1'b0;
      r2       = 1'b0;
      last_pop = e - 100;
   endtask

   task automatic model_edge();
      bit pop, drop;
      pop  = ((e - last_pop) >= S + G + 1) && r2 && (mq.size() > 0);
      drop = 1'b0;
      if (pop) m_txdata = mq.pop_front();
      if (wr_en) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(wr_data);
            sb_q.push_back(wr_data);
         end else begin
            drop = 1'b1;
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      r2 = r1;
      r1 = txready;
      e++;
      if (pop) last_pop = e;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!nrst) model_reset();
      else model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      nrst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; txready = 1'b1;
      model_reset();
      repeat (3) tick();
      checks++;
      if (obs_vec() !== RESET_VEC) begin
         errors++; $display("FAIL reset_held: got %h expected %h", obs_vec(), RESET_VEC);
      end
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs_vec(), RESET_VEC);
         end
      end
   endtask

   task automatic test_single();
      logic exp_clk, exp_busy;
      wr_data = 8'hA5; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         exp_clk  = (k == 3) || (k == 4);
         exp_busy = (k >= 2) && (k <= 5);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL single_model c%0d: got %h expected %h", k, obs_vec(), exp_vec());
         end
         checks++;
         if (txclk !== exp_clk) begin
            errors++; $display("FAIL single_txclk c%0d: got %b expected %b", k, txclk, exp_clk);
         end
         checks++;
         if (busy !== exp_busy) begin
            errors++; $display("FAIL single_busy c%0d: got %b expected %b", k, busy, exp_busy);
         end
         if (k >= 2) begin
            checks++;
            if (txdata !== 8'hA5) begin
               errors++; $display("FAIL single_txdata c%0d: got %h expected a5", k, txdata);
            end
         end
         if (k == 1) begin
            checks++;
            if (count !== 4'd1) begin
               errors++; $display("FAIL single_count: got %0d expected 1", count);
            end
         end
         tick();
      end
   endtask

   task automatic test_burst();
      int scyc[$];
      logic [7:0] sdat[$];
      logic prev;
      int cyc;
      prev = txclk; cyc = 0;
      for (int i = 0; i < 60; i++) begin
         if (i < 8) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
         end else begin
            wr_en = 1'b0;
         end
         tick();
         cyc++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL burst_model c%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
         end
         checks++;
         if (full !== 1'b0) begin
            errors++; $display("FAIL burst_full c%0d: got %b expected 0", cyc, full);
         end
         if (txclk && !prev) begin
            scyc.push_back(cyc);
            sdat.push_back(txdata);
         end
         prev = txclk;
         if (i >= 8 && empty && !busy) break;
      end
      checks++;
      if (scyc.size() != 8) begin
         errors++; $display("FAIL burst_nstrobes: got %0d expected 8", scyc.size());
      end
      for (int i = 0; i < scyc.size(); i++) begin
         checks++;
         if (sdat[i] !== 8'(i + 1)) begin
            errors++; $display("FAIL burst_data[%0d]: got %h expected %h", i, sdat[i], 8'(i + 1));
         end
         if (i > 0) begin
            checks++;
            if (scyc[i] - scyc[i-1] != 2 + S + G) begin
               errors++; $display("FAIL burst_spacing[%0d]: got %0d expected %0d", i, scyc[i] - scyc[i-1], 2 + S + G);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] saved[$];
      logic [7:0] got[$];
      logic prev;
      txready = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; wr_data = 8'($urandom);
         if (i < 8) saved.push_back(wr_data);
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL ovf_fill_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
         if (i == 7) begin
            checks++;
            if (full !== 1'b1) begin
               errors++; $display("FAIL ovf_full_after8: got %b expected 1", full);
            end
         end
      end
      wr_en = 1'b0;
      checks++;
      if (overflow !== 1'b1 || count !== 4'd8) begin
         errors++; $display("FAIL ovf_drop: got ovf=%b count=%0d expected ovf=1 count=8", overflow, count);
      end
      txready = 1'b1; prev = txclk;
      for (int i = 0; i < 100 && !(empty && !busy); i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL ovf_drain_model: got %h expected %h", obs_vec(), exp_vec());
         end
         if (txclk && !prev) got.push_back(txdata);
         prev = txclk;
      end
      checks++;
      if (!(empty && !busy)) begin
         errors++; $display("FAIL ovf_drain_timeout: got empty=%b busy=%b expected 1/0", empty, busy);
      end
      checks++;
      if (got.size() != 8) begin
         errors++; $display("FAIL ovf_nsent: got %0d expected 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== saved[i]) begin
            errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, got[i], saved[i]);
         end
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
      end
   endtask

   task automatic test_flow();
      int nhigh;
      txready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'($urandom);
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 20 && !txclk; i++) tick();
      checks++;
      if (txclk !== 1'b1) begin
         errors++; $display("FAIL flow_wait_strobe: got %b expected 1", txclk);
      end
      txready = 1'b0;
      nhigh = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL flow_low_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
         if (txclk) nhigh++;
      end
      checks++;
      if (nhigh != S) begin
         errors++; $display("FAIL flow_strobe_len: got %0d expected %0d", nhigh, S);
      end
      checks++;
      if (busy !== 1'b0 || count !== 4'd2) begin
         errors++; $display("FAIL flow_paused: got busy=%b count=%0d expected 0/2", busy, count);
      end
      txready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (busy !== (i == 3) || txclk !== 1'b0) begin
            errors++; $display("FAIL flow_resume[%0d]: got busy=%b txclk=%b expected %b/0", i, busy, txclk, (i == 3));
         end
      end
      for (int i = 0; i < 40 && !(empty && !busy); i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL flow_drain_model: got %h expected %h", obs_vec(), exp_vec());
         end
      end
      checks++;
      if (!(empty && !busy)) begin
         errors++; $display("FAIL flow_drain_timeout: got empty=%b busy=%b expected 1/0", empty, busy);
      end
   endtask

   task automatic test_full_simul();
      txready = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'($urandom);
         tick();
      end
      wr_en = 1'b0;
      checks++;
      if (full !== 1'b1) begin
         errors++; $display("FAIL simul_full: got %b expected 1", full);
      end
      txready = 1'b1;
      repeat (2) tick();
      wr_en = 1'b1; wr_data = 8'($urandom);
      tick();
      wr_en = 1'b0;
      checks++;
      if (count !== 4'd8 || overflow !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL simul_pushpop: got count=%0d ovf=%b busy=%b expected 8/0/1", count, overflow, busy);
      end
      for (int i = 0; i < 100 && !(empty && !busy); i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL simul_drain_model: got %h expected %h", obs_vec(), exp_vec());
         end
      end
      checks++;
      if (!(empty && !busy)) begin
         errors++; $display("FAIL simul_drain_timeout: got empty=%b busy=%b expected 1/0", empty, busy);
      end
   endtask

   task automatic test_random();
      logic prev;
      int sent;
      sb_q.delete();
      sent = 0; prev = txclk;
      for (int i = 0; i < 700; i++) begin
         if (i < 400) begin
            wr_en   = ($urandom_range(0, 9) < 4);
            wr_data = 8'($urandom);
            txready = ($urandom_range(0, 9) < 8);
            clr_ovf = ($urandom_range(0, 29) == 0);
         end else begin
            wr_en = 1'b0; clr_ovf = 1'b0; txready = 1'b1;
            if (empty && !busy) break;
         end
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rnd_model c%0d: got %h expected %h", i, obs_vec(), exp_vec());
         end
         if (txclk && !prev) begin
            checks++;
            if (sb_q.size() == 0 || txdata !== sb_q[0]) begin
               errors++; $display("FAIL rnd_order[%0d]: got %h expected %h", sent, txdata, (sb_q.size() > 0) ? sb_q[0] : 8'hxx);
            end
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            sent++;
         end
         prev = txclk;
      end
      checks++;
      if (!(empty && !busy) || sb_q.size() != 0) begin
         errors++; $display("FAIL rnd_drain: got empty=%b busy=%b unsent=%0d expected 1/0/0", empty, busy, sb_q.size());
      end
      checks++;
      if (sent < 20) begin
         errors++; $display("FAIL rnd_wrap: got %0d bytes sent expected at least 20", sent);
      end
   endtask

   task automatic test_reset_mid();
      logic prev;
      int nstrobe;
      txready = 1'b0; clr_ovf = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'($urandom);
         tick();
      end
      wr_en = 1'b0;
      txready = 1'b1;
      for (int i = 0; i < 20 && !txclk; i++) tick();
      checks++;
      if (txclk !== 1'b1 || count !== 4'd3) begin
         errors++; $display("FAIL rmid_setup: got txclk=%b count=%0d expected 1/3", txclk, count);
      end
      #2 nrst = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== RESET_VEC) begin
         errors++; $display("FAIL rmid_async: got %h expected %h", obs_vec(), RESET_VEC);
      end
      model_reset();
      repeat (2) tick();
      nrst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || txclk !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rmid_quiet[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      wr_en = 1'b1; wr_data = 8'h3C;
      tick();
      wr_en = 1'b0;
      prev = txclk; nstrobe = 0;
      for (int i = 0; i < 20 && !(empty && !busy); i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rmid_after_model: got %h expected %h", obs_vec(), exp_vec());
         end
         if (txclk && !prev) begin
            nstrobe++;
            checks++;
            if (txdata !== 8'h3C) begin
               errors++; $display("FAIL rmid_after_data: got %h expected 3c", txdata);
            end
         end
         prev = txclk;
      end
      checks++;
      if (nstrobe != 1) begin
         errors++; $display("FAIL rmid_after_count: got %0d strobes expected 1", nstrobe);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_flow();
      test_full_simul();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Byte-transmit engine for the board's UART output port (`txdata`, `txclk`, `txready`). It buffers bytes written by the core logic in a small FIFO and presents them to the host one at a time. Each byte is a stable `txdata` value followed by a `txclk` strobe, paced by the host's `txready` flow control. It sits between user logic inside `top` and the top-level UART output pins, and is the sending counterpart to the receive pins (`rxdata`, `rxclk`, `rxready`).

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of 2, at least 2.
- `STROBE_CYC`, 2: cycles `txclk` is held high per byte; at least 1.
- `GAP_CYC`, 1: minimum cycles of `txclk` low after each strobe before the next byte is considered; at least 1.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset; asynchronous, active-low.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  8  byte to queue.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `txready`  in  1  host can accept a byte; asynchronous to `clk`.
- `txdata`  out  8  byte presented to the host.
- `txclk`  out  1  strobe; registered, high only in STROBE.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  number of queued bytes, excluding the byte currently being sent.
- `busy`  out  1  state != IDLE.
- `overflow`  out  1  sticky flag: a push was dropped.

## Operation
- `txready` passes through a 2-flop synchronizer; only the synchronized value `rdy_s` is used.
- FIFO: circular buffer with read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a `count` register.
- Push: `wr_en` with `full`=0 writes `wr_data` and increments `count`.
- Push with `full`=1 and no pop in the same cycle: byte dropped, `count` unchanged, `overflow`<=1.
- A simultaneous push and pop is always accepted, including when full; `count` is unchanged.
- `overflow` clears on `clr_ovf`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- FSM states: IDLE, SETUP, STROBE, GAP.
  - IDLE: if `rdy_s`=1 and `empty`=0: pop the head into `txdata`, advance the read pointer, go to SETUP. Otherwise stay.
  - SETUP: one cycle; `txdata` is stable and `txclk`=0. Go to STROBE.
  - STROBE: `txclk`=1 for exactly STROBE_CYC cycles (down-counter), then go to GAP.
  - GAP: `txclk`=0 for GAP_CYC cycles, then go to IDLE.
- `txdata` holds its value from SETUP until the next pop, including while idle.
- `rdy_s` is sampled only in IDLE. Deasserting `txready` mid-byte never aborts or stretches the byte in progress.
- Reset (asynchronous, any state):
  - FSM goes to IDLE and both pointers to 0.
  - `count`=0, `txdata`=8'h00, `txclk`=0, `overflow`=0, synchronizer flops 0.
  - `full`=0, `empty`=1, `busy`=0.
  - Queued bytes are discarded; a strobe in progress is cut off immediately.

## Timing
- `txready` to `rdy_s`: 2 cycles.
- Example with `rdy_s`=1, idle, empty FIFO, `wr_en` in cycle 0:
  - `count`=1 in cycle 1; pop decision in cycle 1.
  - SETUP in cycle 2, with `txdata` valid.
  - `txclk` high in cycles 3 to 2+STROBE_CYC.
  - GAP in cycles 3+STROBE_CYC to 2+STROBE_CYC+GAP_CYC.
  - IDLE in cycle 3+STROBE_CYC+GAP_CYC.
- Back-to-back byte period is 2+STROBE_CYC+GAP_CYC cycles; 5 cycles with the defaults.
- A pop decrements `count` in the cycle after the IDLE decision, the same edge that enters SETUP.
- `full`, `empty` and `count` are derived from registered state; there is no combinational path from `wr_en`.
- `txdata` never changes while `txclk`=1, nor in the cycle before or after the strobe.

## Test plan
- Reset, then single byte:
  - Hold `txready`=1; push 8'hA5 at cycle 0.
  - `txdata`=8'hA5 from cycle 2; `txclk`=1 only in cycles 3 and 4; `busy` deasserts at cycle 6.
  - All outputs match their reset values before cycle 0.
- Burst: push 8'h01 to 8'h08 on consecutive cycles with `txready`=1. The host sees 8 strobes in order 01 to 08, each 5 cycles apart; `full` stays 0 because pops overlap pushes.
- Overflow: hold `txready`=0 and push 9 bytes. `full`=1 after the 8th push, the 9th is dropped, `overflow`=1. Raise `txready`: exactly 8 bytes are sent, then `empty`=1. Pulse `clr_ovf`: `overflow`=0.
- Flow control: drop `txready` during a strobe. The current byte completes. No new SETUP occurs until 2 cycles after `txready` rises again.
- Wrap and simultaneous events:
  - Send 20 bytes through the FIFO; pointers wrap and data order is preserved.
  - With the FIFO full, push in the same cycle as a pop: byte accepted, `count` stays 8, `overflow` stays 0.
- Reset mid-strobe: assert `nrst`=0 while `txclk`=1 with 3 bytes queued. `txclk`=0 immediately and `count`=0. After release, nothing is sent until a new push.
